antilog_calc: RTL

Inverse of the log-compression normalizer stage in the ultrasound logc path. Takes a base-2 exponent (`int_part`) and a normalized mantissa with hidden leading one, and reconstructs the linear sample value `round(mantissa * 2^int_part)`, saturated to `DATA_WIDTH` bits. Used on the decompression/display side and in loopback verification of the compression chain. Multi-cycle FSM with valid/ready handshakes on both sides.

---
 rtl/antilog_calc.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/antilog_calc.sv
// -----------------------------------------------------------------------------
// antilog_calc
//
// Reconstructs a linear sample from its log-compressed form: takes a base-2
// exponent and a normalized mantissa (hidden leading one, FRAC_WIDTH fraction
// bits) and produces round(mantissa * 2^exponent), saturated to DATA_WIDTH
// bits. Used on the decompression/display side and for compression-chain
// loopback. One sample in flight at a time through a four-state FSM.
//
// Handshake rule (both sides): a word moves on a rising clk edge where
// valid and ready are both 1. in_ready depends only on the FSM state, never
// on out_ready. Once out_valid rises, data_out/sat/fmt_err are held stable
// until the edge where out_ready is seen high.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   in_valid   in   input word valid
//   in_ready   out  block is in IDLE and can accept a word
//   int_part   in   [SHIFT_WIDTH] exponent
//   data_in    in   [NORM_WIDTH] mantissa, MSB = hidden one
//   out_valid  out  result valid
//   out_ready  in   downstream accepts result
//   data_out   out  [DATA_WIDTH] reconstructed linear value
//   sat        out  result was saturated
//   fmt_err    out  hidden bit of the captured mantissa was 0
//   dbg_state  out  [2] current FSM state (IDLE=0 SHIFT=1 ROUND=2 SEND=3)
// -----------------------------------------------------------------------------
module antilog_calc #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_WIDTH  = 16,
    parameter int NORM_WIDTH  = FRAC_WIDTH + 1,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH),
    parameter int ROUND_EN    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SHIFT_WIDTH-1:0] int_part,
    input  logic [NORM_WIDTH-1:0]  data_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   sat,
    output logic                   fmt_err,
    output logic [1:0]             dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] SEND  = 2'd3;

    // Full shifted product width.
    localparam int WIDE_W = NORM_WIDTH + DATA_WIDTH;
    // Only the integer part plus the rounding bit are kept; fraction bits
    // below the rounding bit never affect the result (round half up).
    localparam int KEEP_W = WIDE_W - (FRAC_WIDTH - 1);
    // Integer part (DATA_WIDTH+1) plus one bit of headroom for the round add.
    localparam int Q_W    = DATA_WIDTH + 2;

    logic [1:0]             r_state;
    logic [SHIFT_WIDTH-1:0] r_exp;
    logic [NORM_WIDTH-1:0]  r_man;
    logic [KEEP_W-1:0]      r_wide;
    logic                   r_ovf;
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_data_out;
    logic                   r_sat;
    logic                   r_fmt_err;

    logic [KEEP_W-1:0]      w_shift_keep;
    logic [31:0]            w_exp_ext;
    logic                   w_exp_ovf;
    logic [Q_W-1:0]         w_q_trunc;
    logic                   w_round_bit;
    logic [Q_W-1:0]         w_q;
    logic                   w_q_big;

    // mantissa << exponent in the full product width, then drop the fraction
    // bits below the rounding position.
    assign w_shift_keep = KEEP_W'(({{DATA_WIDTH{1'b0}}, r_man} << r_exp) >> (FRAC_WIDTH - 1));

    // Exponent beyond DATA_WIDTH-1 is only reachable when DATA_WIDTH is not a
    // power of two; compare in 32 bits so the check stays generic.
    assign w_exp_ext = 32'(r_exp);
    assign w_exp_ovf = (w_exp_ext > 32'(DATA_WIDTH - 1));

    // r_wide[0] is the first dropped fraction bit, r_wide[KEEP_W-1:1] the
    // DATA_WIDTH+1 bit integer part.
    assign w_q_trunc   = {1'b0, r_wide[KEEP_W-1:1]};
    assign w_round_bit = (ROUND_EN != 0) ? r_wide[0] : 1'b0;
    assign w_q         = w_q_trunc + {{(Q_W-1){1'b0}}, w_round_bit};
    assign w_q_big     = |w_q[Q_W-1:DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_exp       <= '0;
            r_man       <= '0;
            r_wide      <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_sat       <= 1'b0;
            r_fmt_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_exp   <= int_part;
                        r_man   <= data_in;
                        r_ovf   <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_wide  <= w_shift_keep;
                    r_ovf   <= w_exp_ovf;
                    r_state <= ROUND;
                end
                ROUND: begin
                    if (w_q_big || r_ovf) begin
                        r_data_out <= '1;
                        r_sat      <= 1'b1;
                    end else begin
                        r_data_out <= w_q[DATA_WIDTH-1:0];
                        r_sat      <= 1'b0;
                    end
                    // Flag only: the mantissa is used exactly as supplied.
                    r_fmt_err   <= ~r_man[NORM_WIDTH-1];
                    r_out_valid <= 1'b1;
                    r_state     <= SEND;
                end
                SEND: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign sat       = r_sat;
    assign fmt_err   = r_fmt_err;
    assign dbg_state = r_state;

endmodule
